// File: rtl/cpu_fsm_pkg.sv
// Shared constants and state encoding for the instruction-sequencing FSMs.
package cpu_fsm_pkg;

  localparam int unsigned BUS_W     = 16;
  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned NREGS     = 4;
  localparam int unsigned SEL_W     = $clog2(NREGS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_idx_decoder.sv
// Register index to one-hot enable decoder; flags indices beyond R0..R3.
module reg_idx_decoder
  import cpu_fsm_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot,
  output logic             bad
);

  assign bad    = |idx[IDX_W-1:SEL_W];
  assign onehot = (en && !bad) ? (NREGS'(1) << idx[SEL_W-1:0]) : '0;

endmodule

// File: rtl/movr_fsm.sv
// MOV Ri, Rj sequencer: read Rj into temp, drive temp back with Ri's write
// enable, then pulse start_next_I. All outputs are registered.
module movr_fsm
  import cpu_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = BUS_W,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] Ri,
  input  logic [IDX_W-1:0] Rj,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] out_to_bus,
  output logic             bus_drive,
  output logic             R0_read,
  output logic             R1_read,
  output logic             R2_read,
  output logic             R3_read,
  output logic             R0_write,
  output logic             R1_write,
  output logic             R2_write,
  output logic             R3_write,
  output logic             start_next_I,
  output logic             illegal,
  output logic             busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   di_q, si_q, di_d, si_d;
  logic               ill_q, ill_d;
  logic [WIDTH-1:0]   temp_q, temp_d;
  logic               take;
  logic               rd_en, wr_en, rd_bad, wr_bad;
  logic [NREGS-1:0]   rd_oh, wr_oh;

  // Indices are captured only on the accepting IDLE edge.
  assign take = (state_q == ST_IDLE) && start;
  assign di_d = take ? Ri : di_q;
  assign si_d = take ? Rj : si_q;

  assign rd_en = (state_d == ST_READ);
  assign wr_en = (state_d == ST_DRIVE);

  reg_idx_decoder #(.IDX_W(IDX_W)) u_rd_dec (
    .idx    (si_d),
    .en     (rd_en),
    .onehot (rd_oh),
    .bad    (rd_bad)
  );

  reg_idx_decoder #(.IDX_W(IDX_W)) u_wr_dec (
    .idx    (di_d),
    .en     (wr_en),
    .onehot (wr_oh),
    .bad    (wr_bad)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    temp_d  = temp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ill_d   = rd_bad | wr_bad;
          state_d = (rd_bad | wr_bad) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        temp_d  = bus_in;
        state_d = ST_DRIVE;
      end
      ST_DRIVE: state_d = ST_DONE;
      ST_DONE: begin
        ill_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      di_q         <= '0;
      si_q         <= '0;
      ill_q        <= 1'b0;
      temp_q       <= '0;
      out_to_bus   <= '0;
      bus_drive    <= 1'b0;
      R0_read      <= 1'b0;
      R1_read      <= 1'b0;
      R2_read      <= 1'b0;
      R3_read      <= 1'b0;
      R0_write     <= 1'b0;
      R1_write     <= 1'b0;
      R2_write     <= 1'b0;
      R3_write     <= 1'b0;
      start_next_I <= 1'b0;
      illegal      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      di_q         <= di_d;
      si_q         <= si_d;
      ill_q        <= ill_d;
      temp_q       <= temp_d;
      out_to_bus   <= (state_d == ST_DRIVE) ? temp_d : '0;
      bus_drive    <= (state_d == ST_DRIVE);
      R0_read      <= rd_oh[0];
      R1_read      <= rd_oh[1];
      R2_read      <= rd_oh[2];
      R3_read      <= rd_oh[3];
      R0_write     <= wr_oh[0];
      R1_write     <= wr_oh[1];
      R2_write     <= wr_oh[2];
      R3_write     <= wr_oh[3];
      start_next_I <= (state_d == ST_DONE);
      illegal      <= (state_d == ST_DONE) && ill_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: doc/movr_fsm.md
Name: movr_fsm

Overview:
- Register-to-register move FSM (MOV Ri, Rj) for the simple CPU control path.
- It is the read-side counterpart of the immediate-move FSM: it asserts the read enable of source register Rj and captures the bus value into a temp latch.
- It then drives that value back onto the bus with the write enable of destination Ri.
- It pulses start_next_I on completion and hands control to the next instruction FSM, using the same start/start_next_I chaining as the other instruction FSMs.

Parameters:
WIDTH, 16, data bus width
IDX_W, 6, register index field width from instruction decode
NREGS, 4, number of architectural registers (R0..R3); index bits above log2(NREGS) must be zero

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin instruction; sampled on rising clk in IDLE only
Ri  input  IDX_W  destination register index
Rj  input  IDX_W  source register index
bus_in  input  WIDTH  shared data bus as seen by this FSM
out_to_bus  output  WIDTH  data driven to bus; 0 when bus_drive=0
bus_drive  output  1  bus output enable for out_to_bus
R0_read..R3_read  output  1 each  source register bus-read enables, one-hot or zero
R0_write..R3_write  output  1 each  destination register write enables, one-hot or zero
start_next_I  output  1  one-cycle completion pulse
illegal  output  1  one-cycle pulse, coincident with start_next_I, on bad index
busy  output  1  high in any state except IDLE

Behaviour:
Reset:
- reset=0 asynchronously forces state=IDLE and temp=0.
- All outputs go to 0: out_to_bus, bus_drive, all R*_read, all R*_write, start_next_I, illegal, busy.

Reset mid-operation:
- Aborts immediately; no write occurs and no start_next_I is issued.
- After reset release, the FSM waits in IDLE for a fresh start.

States, all outputs registered or decoded from state and latched indices:
- IDLE: busy=0, all enables 0. On a rising edge with start=1, latch Ri→di and Rj→si.
  - If di[IDX_W-1:2]!=0 or si[IDX_W-1:2]!=0, go to DONE with illegal flag set.
  - Otherwise go to READ.
- READ (1 cycle): R{si}_read=1, other reads 0. On the closing edge, temp<=bus_in. Go to DRIVE.
- DRIVE (1 cycle): bus_drive=1, out_to_bus=temp, R{di}_write=1, all reads 0. Go to DONE.
- DONE (1 cycle): start_next_I=1; illegal=1 only if the illegal flag is set. Clear the flag. Go to IDLE.

Timing and latency (start sampled at edge N):
- READ spans N..N+1; DRIVE N+1..N+2; DONE N+2..N+3; back in IDLE after N+3.
- Illegal path: DONE spans N..N+1.

Rules and boundary conditions:
- start while busy=1 is ignored; no queuing.
- start held high continuously re-triggers only on the IDLE-state edge after DONE.
- Ri==Rj is legal: the register is read then rewritten with the same value.
- Read and write enables are never high in the same cycle.
- At most one R*_read and one R*_write are high at any time.
- Changes on Ri/Rj after the start edge have no effect (indices are latched).
- The temp latch holds its value in IDLE and is not cleared except by reset.
- Width rule: data passes through unmodified, with no arithmetic; temp is exactly WIDTH bits.

Decomposition:
- Shared package cpu_fsm_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_READ=2'd1, ST_DRIVE=2'd2, ST_DONE=2'd3;
  - NREGS and the register index width;
  - the bus width default of 16.
  All instruction FSMs use it.
- One sub-module, reg_idx_decoder, turns (idx[IDX_W-1:0], en) into a one-hot 4-bit output plus a bad flag (high bits nonzero). It is instantiated twice, once for the read enables and once for the write enables, and is reusable by the Movi FSM.

Test Plan:
1. Reset: pulse reset low for 2 ns mid-cycle → all outputs 0 immediately, busy=0, no start_next_I until a later start.
2. Basic move: preload the bus model so R2 returns 16'h00AB; Ri=1, Rj=2, 4 ns start pulse → R2_read high one cycle; next cycle bus_drive=1, out_to_bus=16'h00AB, R1_write=1; next cycle start_next_I=1; busy falls after 3 cycles.
3. Self move: Ri=Rj=3, R3=16'hFFFF → R3_read then R3_write with out_to_bus=16'hFFFF; no cycle has both enables high.
4. Illegal index: Ri=6'd5, Rj=0, start → next cycle start_next_I=1 and illegal=1; no R*_read, R*_write or bus_drive ever asserted.
5. Start while busy: second start pulse during DRIVE with Ri=0 → ignored; only one completion pulse and R0_write never asserted.
6. Abort: assert reset low during DRIVE → R*_write and bus_drive drop asynchronously; no start_next_I; a subsequent start with Ri=0, Rj=1 completes normally.
